ecc_secded_pipe: RTL
====================

// Module: ecc_secded_pipe
// PURPOSE
//   Parametrised SECDED Hamming codec for the MRAM write/read datapath. Encode channel turns
//   DATA_W-bit words into {parity, data} codewords. Decode channel corrects single-bit errors
//   and flags double-bit errors. Both channels use registered valid/ready handshakes.
//   Also provides saturating SEC/DED counters and one-shot error injection for in-system test.
// PARAMETERS
//   DATA_W  8  data width (>=4); HAM_W = min r with 2^r >= DATA_W+r+1; PAR_W = HAM_W+1; CW_W = DATA_W+PAR_W
//   CNT_W   16 width of each error counter
// PORTS
//   clk_i       in   1      clock
//   rst_ni      in   1      asynchronous reset, active-low
//   enc_vld_i   in   1      encode input valid
//   enc_rdy_o   out  1      encode input ready
//   enc_d_i     in   DATA_W data to encode
//   enc_vld_o   out  1      codeword valid
//   enc_rdy_i   in   1      codeword ready
//   enc_q_o     out  CW_W   codeword {parity[PAR_W-1:0], data[DATA_W-1:0]}
//   dec_vld_i   in   1      decode input valid
//   dec_rdy_o   out  1      decode input ready
//   dec_q_i     in   CW_W   received codeword
//   dec_vld_o   out  1      decoded result valid
//   dec_rdy_i   in   1      decoded result ready
//   dec_d_o     out  DATA_W corrected data
//   dec_sec_o   out  1      single error detected and corrected
//   dec_ded_o   out  1      uncorrectable error; data passed uncorrected
//   inj_arm_i   in   1      pulse: arm injection for the next accepted encode
//   inj_mode_i  in   2      0 none, 1 flip bit inj_pos_i, 2 flip inj_pos_i and (inj_pos_i+1) mod CW_W
//   inj_pos_i   in   8      codeword bit index; index >= CW_W flips nothing
//   cnt_clr_i   in   1      synchronous clear of both counters
//   sec_cnt_o   out  CNT_W  saturating count of SEC results
//   ded_cnt_o   out  CNT_W  saturating count of DED results
// BEHAVIOUR
//   Reset: all valid outputs 0. Data/flag outputs 0. Counters 0. Injection disarmed. In-flight words are dropped.
//   Encode parity:
//     - Data bit k takes the k-th non-power-of-two Hamming position (3,5,6,7,9,...).
//     - p[j], j<HAM_W = XOR of data bits whose position has bit j set.
//     - p[HAM_W] = XOR of p[HAM_W-1:0] and all data bits.
//   Each channel is one output register stage. Latency is 1 cycle. Throughput is 1 word/cycle.
//   Handshake:
//     - Transfer occurs when vld & rdy are both high.
//     - in_rdy = ~out_vld | out_rdy (combinational).
//     - While out_vld & ~out_rdy, the output payload and flags stay stable.
//     - out_vld drops only after a transfer with no new input.
//   Injection:
//     - inj_arm_i sets the armed flag and captures inj_mode_i/inj_pos_i.
//     - The next encode input transfer XORs the selected bits into the registered codeword, then disarms.
//     - Mode 0 disarms without flipping.
//     - Arm arriving in the same cycle as a transfer applies to the following word.
//   Decode:
//     - s = recomputed Hamming parity XOR received p[HAM_W-1:0].
//     - o = XOR of all CW_W received bits.
//     - s==0, o==0: clean; sec=0, ded=0.
//     - o==1, s==0: overall-parity bit error; sec=1, data unchanged.
//     - o==1, s is a power of two: parity bit error; sec=1, data unchanged.
//     - o==1, s is a data position <= DATA_W+HAM_W: flip that data bit; sec=1.
//     - o==1, s out of range: ded=1, data uncorrected.
//     - s!=0, o==0: double error; ded=1, data uncorrected.
//     - sec and ded are never both 1.
//   Counters:
//     - Increment on decode output transfer (dec_vld_o & dec_rdy_i) when the matching flag is set.
//     - Saturate at all-ones.
//     - cnt_clr_i takes priority; a coincident increment is lost.
// TESTING (DATA_W=8, CW_W=13)
//   Encode 0xA5 -> enc_q_o=13'h03A5 one cycle after transfer; decode 13'h03A5 -> 0xA5, sec=0, ded=0.
//   Decode 13'h03A1 (data bit 2 flipped) -> 0xA5, sec=1, sec_cnt_o=1.
//   Decode 13'h13A5 (bit 12 flipped) -> 0xA5, sec=1.
//   Decode 13'h03A6 (bits 0,1 flipped) -> 0xA6, ded=1, ded_cnt_o=1.
//   Arm mode 1 pos 0, encode 0xA5 twice -> 13'h03A4, then 13'h03A5.
//   Hold dec_rdy_i=0 for 3 cycles with dec_vld_o=1 -> outputs stable, dec_rdy_o=0, no counts.
//   Streaming at full rate loses no words.
//   CNT_W=2, 5 SEC results -> sec_cnt_o=3. cnt_clr_i -> 0.
//   Reset asserted mid-stream -> valids drop immediately.

Source files
------------

// File: rtl/ecc_secded_pipe_if.sv
// Handshake and status bundle for the SECDED codec: encode channel, decode channel,
// error-injection controls and error counters.
interface ecc_secded_pipe_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
);

  function automatic int calc_ham_w(int dw);
    int r;
    r = 1;
    while ((1 << r) < dw + r + 1) r++;
    return r;
  endfunction

  localparam int HAM_W = calc_ham_w(DATA_W);
  localparam int PAR_W = HAM_W + 1;
  localparam int CW_W  = DATA_W + PAR_W;

  logic              enc_vld_i;
  logic              enc_rdy_o;
  logic [DATA_W-1:0] enc_d_i;
  logic              enc_vld_o;
  logic              enc_rdy_i;
  logic [CW_W-1:0]   enc_q_o;

  logic              dec_vld_i;
  logic              dec_rdy_o;
  logic [CW_W-1:0]   dec_q_i;
  logic              dec_vld_o;
  logic              dec_rdy_i;
  logic [DATA_W-1:0] dec_d_o;
  logic              dec_sec_o;
  logic              dec_ded_o;

  logic              inj_arm_i;
  logic [1:0]        inj_mode_i;
  logic [7:0]        inj_pos_i;

  logic              cnt_clr_i;
  logic [CNT_W-1:0]  sec_cnt_o;
  logic [CNT_W-1:0]  ded_cnt_o;

  modport master (
    output enc_vld_i, enc_d_i, enc_rdy_i,
    output dec_vld_i, dec_q_i, dec_rdy_i,
    output inj_arm_i, inj_mode_i, inj_pos_i, cnt_clr_i,
    input  enc_rdy_o, enc_vld_o, enc_q_o,
    input  dec_rdy_o, dec_vld_o, dec_d_o, dec_sec_o, dec_ded_o,
    input  sec_cnt_o, ded_cnt_o
  );

  modport slave (
    input  enc_vld_i, enc_d_i, enc_rdy_i,
    input  dec_vld_i, dec_q_i, dec_rdy_i,
    input  inj_arm_i, inj_mode_i, inj_pos_i, cnt_clr_i,
    output enc_rdy_o, enc_vld_o, enc_q_o,
    output dec_rdy_o, dec_vld_o, dec_d_o, dec_sec_o, dec_ded_o,
    output sec_cnt_o, ded_cnt_o
  );

endinterface

// File: rtl/ecc_secded_pipe.sv
// Parametrised SECDED Hamming encoder/decoder with one register stage per channel,
// one-shot codeword error injection and saturating SEC/DED counters.
module ecc_secded_pipe #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  ecc_secded_pipe_if.slave   bus
);

  function automatic int calc_ham_w(int dw);
    int r;
    r = 1;
    while ((1 << r) < dw + r + 1) r++;
    return r;
  endfunction

  localparam int HAM_W = calc_ham_w(DATA_W);
  localparam int PAR_W = HAM_W + 1;
  localparam int CW_W  = DATA_W + PAR_W;
  localparam int MAX_POS = DATA_W + HAM_W;

  // Hamming check bits: XOR of the positions of all set data bits, where data bit k
  // sits at the k-th non-power-of-two position.
  function automatic logic [HAM_W-1:0] ham_par(logic [DATA_W-1:0] d);
    logic [HAM_W-1:0]  h;
    logic [DATA_W-1:0] sh;
    int                k;
    h = '0;
    k = 0;
    for (int p = 1; p <= MAX_POS; p++) begin
      if ((p & (p - 1)) != 0) begin
        sh = d >> k;
        if (sh[0]) h = h ^ HAM_W'(p);
        k++;
      end
    end
    return h;
  endfunction

  function automatic logic [PAR_W-1:0] enc_parity(logic [DATA_W-1:0] d);
    logic [HAM_W-1:0] h;
    h = ham_par(d);
    return {(^h) ^ (^d), h};
  endfunction

  // Data-bit mask selecting the bit that lives at Hamming position s (empty if none).
  function automatic logic [DATA_W-1:0] flip_mask(logic [HAM_W-1:0] s);
    logic [DATA_W-1:0] m;
    int                k;
    m = '0;
    k = 0;
    for (int p = 1; p <= MAX_POS; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (HAM_W'(p) == s) m = m | (DATA_W'(1) << k);
        k++;
      end
    end
    return m;
  endfunction

  function automatic logic [CW_W-1:0] inj_mask(logic [1:0] mode, logic [7:0] pos);
    logic [CW_W-1:0] m;
    int              p;
    int              q;
    m = '0;
    p = int'(pos);
    if (p < CW_W) begin
      if (mode == 2'd1 || mode == 2'd2) m = m | (CW_W'(1) << p);
      if (mode == 2'd2) begin
        q = (p + 1) % CW_W;
        m = m | (CW_W'(1) << q);
      end
    end
    return m;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic              enc_vld_p1;
  logic [CW_W-1:0]   enc_q_p1;
  logic              dec_vld_p1;
  logic [DATA_W-1:0] dec_d_p1;
  logic              dec_sec_p1;
  logic              dec_ded_p1;
  logic              inj_armed;
  logic [1:0]        inj_mode_q;
  logic [7:0]        inj_pos_q;
  logic [CNT_W-1:0]  sec_cnt;
  logic [CNT_W-1:0]  ded_cnt;

  logic              enc_fire_p0;
  logic              dec_fire_p0;
  logic              dec_out_fire;
  logic [CW_W-1:0]   enc_cw_p0;
  logic [DATA_W-1:0] dec_d_p0;
  logic              dec_sec_p0;
  logic              dec_ded_p0;
  logic [DATA_W-1:0] rx_d;
  logic [HAM_W-1:0]  rx_p;
  logic [HAM_W-1:0]  syn;
  logic              ovr;

  assign bus.enc_rdy_o = ~enc_vld_p1 | bus.enc_rdy_i;
  assign bus.dec_rdy_o = ~dec_vld_p1 | bus.dec_rdy_i;
  assign enc_fire_p0   = bus.enc_vld_i & bus.enc_rdy_o;
  assign dec_fire_p0   = bus.dec_vld_i & bus.dec_rdy_o;
  assign dec_out_fire  = dec_vld_p1 & bus.dec_rdy_i;

  // ---- stage p0: combinational encode / decode ----
  always_comb begin
    enc_cw_p0 = {enc_parity(bus.enc_d_i), bus.enc_d_i};
    if (inj_armed) enc_cw_p0 = enc_cw_p0 ^ inj_mask(inj_mode_q, inj_pos_q);
  end

  assign rx_d = bus.dec_q_i[DATA_W-1:0];
  assign rx_p = bus.dec_q_i[DATA_W +: HAM_W];
  assign syn  = ham_par(rx_d) ^ rx_p;
  assign ovr  = ^bus.dec_q_i;

  always_comb begin
    dec_d_p0   = rx_d;
    dec_sec_p0 = 1'b0;
    dec_ded_p0 = 1'b0;
    if (ovr) begin
      // Zero syndrome or a power of two means the flipped bit was a parity bit.
      if ((syn & (syn - HAM_W'(1))) == '0) begin
        dec_sec_p0 = 1'b1;
      end else if (int'(syn) <= MAX_POS) begin
        dec_sec_p0 = 1'b1;
        dec_d_p0   = rx_d ^ flip_mask(syn);
      end else begin
        dec_ded_p0 = 1'b1;
      end
    end else if (syn != '0) begin
      dec_ded_p0 = 1'b1;
    end
  end

  // ---- stage p1: output registers ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      enc_vld_p1 <= 1'b0;
      enc_q_p1   <= '0;
    end else if (enc_fire_p0) begin
      enc_vld_p1 <= 1'b1;
      enc_q_p1   <= enc_cw_p0;
    end else if (bus.enc_rdy_i) begin
      enc_vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dec_vld_p1 <= 1'b0;
      dec_d_p1   <= '0;
      dec_sec_p1 <= 1'b0;
      dec_ded_p1 <= 1'b0;
    end else if (dec_fire_p0) begin
      dec_vld_p1 <= 1'b1;
      dec_d_p1   <= dec_d_p0;
      dec_sec_p1 <= dec_sec_p0;
      dec_ded_p1 <= dec_ded_p0;
    end else if (bus.dec_rdy_i) begin
      dec_vld_p1 <= 1'b0;
    end
  end

  // A new arm in the same cycle as a transfer re-arms for the following word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inj_armed  <= 1'b0;
      inj_mode_q <= '0;
      inj_pos_q  <= '0;
    end else begin
      if (enc_fire_p0) inj_armed <= 1'b0;
      if (bus.inj_arm_i) begin
        inj_armed  <= 1'b1;
        inj_mode_q <= bus.inj_mode_i;
        inj_pos_q  <= bus.inj_pos_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sec_cnt <= '0;
      ded_cnt <= '0;
    end else if (bus.cnt_clr_i) begin
      sec_cnt <= '0;
      ded_cnt <= '0;
    end else if (dec_out_fire) begin
      if (dec_sec_p1) sec_cnt <= sat_inc(sec_cnt);
      if (dec_ded_p1) ded_cnt <= sat_inc(ded_cnt);
    end
  end

  assign bus.enc_vld_o = enc_vld_p1;
  assign bus.enc_q_o   = enc_q_p1;
  assign bus.dec_vld_o = dec_vld_p1;
  assign bus.dec_d_o   = dec_d_p1;
  assign bus.dec_sec_o = dec_sec_p1;
  assign bus.dec_ded_o = dec_ded_p1;
  assign bus.sec_cnt_o = sec_cnt;
  assign bus.ded_cnt_o = ded_cnt;

endmodule
